// File: rtl/signed_seg_display.sv
// Signed 16-bit value to sign + 5 BCD digits (sequential double-dabble),
// shown through a scrollable 4-digit window on a multiplexed 7-segment display.
module signed_seg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        scroll_l,
  input  logic        scroll_r,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t        state;
  logic          sign;
  logic [15:0]   mag;
  logic [19:0]   bcd;
  logic [3:0]    bit_cnt;
  logic          buf_sign;
  logic [19:0]   buf_digits;
  logic [1:0]    offset;
  logic [1:0]    scan;
  logic [CW-1:0] refresh_cnt;

  logic [35:0]   step;
  logic [2:0]    pos;
  logic [6:0]    char_seg;

  function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++)
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0: encode = 7'h40;
      4'd1: encode = 7'h79;
      4'd2: encode = 7'h24;
      4'd3: encode = 7'h30;
      4'd4: encode = 7'h19;
      4'd5: encode = 7'h12;
      4'd6: encode = 7'h02;
      4'd7: encode = 7'h78;
      4'd8: encode = 7'h00;
      4'd9: encode = 7'h10;
      default: encode = 7'h7F;
    endcase
  endfunction

  // One double-dabble iteration: add-3 correction, then shift {bcd, mag} left.
  always_comb begin
    step = {dabble_adjust(bcd), mag};
    pos  = {1'b0, scan} + {1'b0, offset};
    case (pos)
      3'd0:    char_seg = encode(buf_digits[3:0]);
      3'd1:    char_seg = encode(buf_digits[7:4]);
      3'd2:    char_seg = encode(buf_digits[11:8]);
      3'd3:    char_seg = encode(buf_digits[15:12]);
      3'd4:    char_seg = encode(buf_digits[19:16]);
      3'd5:    char_seg = buf_sign ? 7'h3F : 7'h7F;
      default: char_seg = 7'h7F;
    endcase
  end

  // busy stays high one cycle past UPDATE, so a load in that cycle is still ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sign       <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      buf_sign   <= 1'b0;
      buf_digits <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (load) begin
            sign    <= value[15];
            mag     <= value[15] ? (~value + 16'd1) : value;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd     <= step[34:15];
          mag     <= {mag[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= UPDATE;
        end
        UPDATE: begin
          buf_sign   <= sign;
          buf_digits <= bcd;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset <= 2'd0;
    end else if (scroll_l && !scroll_r && offset != 2'd2) begin
      offset <= offset + 2'd1;
    end else if (scroll_r && !scroll_l && offset != 2'd0) begin
      offset <= offset - 2'd1;
    end
  end

  // seg/an/dp are all derived from the same cycle's scan, so they stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      scan        <= 2'd0;
      seg         <= 7'h7F;
      an          <= 4'hF;
      dp          <= 1'b1;
    end else begin
      if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        scan        <= scan + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << scan);
      seg <= char_seg;
      dp  <= !((scan == 2'd3) && (offset != 2'd2));
    end
  end

endmodule
